rgb_compare_pwm: RTL

Parametrised, clocked successor to the 2-bit combinational RGB comparator. Compares two WIDTH-bit switch inputs and drives the RGB LED: red for a>b, green for a==b, blue for a<b. Adds input synchronisation, a stability filter so switch bounce never reaches the LEDs, and PWM brightness control. Sits between the board switches and the RGB LED pins.

---
 rtl/rgb_compare_pwm.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/rgb_compare_pwm.sv
`default_nettype none
// ============================================================================
// Module      : rgb_compare_pwm
// Description : Clocked magnitude comparator driving an RGB LED.
//               The two switch operands are synchronised, the comparison
//               result is qualified for STABLE_CYCLES consecutive cycles
//               before it is committed, and the selected LED is
//               brightness-modulated by a free-running PWM.
//               Codes: 00 none, 01 GT (red), 10 EQ (green), 11 LT (blue).
// Build macro : CMP_SIGNED_EN - when defined, operands are compared as
//               two's-complement signed values; otherwise they are unsigned.
// Ports       : clk          - system clock, rising edge
//               rst          - asynchronous active-high reset
//               a, b         - WIDTH-bit operands from asynchronous switches
//               duty         - PWM_BITS brightness; LED on while pwm_cnt < duty
//               red/green/blue - registered, PWM-gated LED drives
//               cmp_code     - committed comparison code
//               result_valid - high once the first result has been committed
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_compare_pwm #(
  parameter int WIDTH         = 8,
  parameter int PWM_BITS      = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [PWM_BITS-1:0] duty,
  output logic                red,
  output logic                green,
  output logic                blue,
  output logic [1:0]          cmp_code,
  output logic                result_valid
);

  localparam int c_cnt_w = $clog2(STABLE_CYCLES) + 1;

  localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
  localparam logic [PWM_BITS-1:0] c_pwm_max  = '1;
  localparam logic [PWM_BITS-1:0] c_pwm_one  = PWM_BITS'(1);

  localparam logic [1:0] c_code_none = 2'b00;
  localparam logic [1:0] c_code_gt   = 2'b01;
  localparam logic [1:0] c_code_eq   = 2'b10;
  localparam logic [1:0] c_code_lt   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLING = 2'd1,
    S_LOCKED   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [WIDTH-1:0]     r_a_s1;
  logic [WIDTH-1:0]     r_a_s2;
  logic [WIDTH-1:0]     r_b_s1;
  logic [WIDTH-1:0]     r_b_s2;

  logic                 w_a_gt_b;
  logic                 w_a_lt_b;
  logic [1:0]           w_raw;

  logic [1:0]           r_cand;
  logic [1:0]           w_cand_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [1:0]           r_committed;
  logic [1:0]           w_committed_nxt;
  logic                 r_valid;
  logic                 w_valid_nxt;

  logic [PWM_BITS-1:0]  r_pwm_cnt;
  logic [PWM_BITS-1:0]  r_duty_q;
  logic                 w_pwm_on;

  // --------------------------------------------------------------------------
  // Two-flop synchronisers on the switch inputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_s1 <= '0;
      r_a_s2 <= '0;
      r_b_s1 <= '0;
      r_b_s2 <= '0;
    end else begin
      r_a_s1 <= a;
      r_a_s2 <= r_a_s1;
      r_b_s1 <= b;
      r_b_s2 <= r_b_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Raw comparison of the synchronised operands
  // --------------------------------------------------------------------------
`ifdef CMP_SIGNED_EN
  assign w_a_gt_b = $signed(r_a_s2) > $signed(r_b_s2);
  assign w_a_lt_b = $signed(r_a_s2) < $signed(r_b_s2);
`else
  assign w_a_gt_b = r_a_s2 > r_b_s2;
  assign w_a_lt_b = r_a_s2 < r_b_s2;
`endif

  // The raw code is never "none", so a freshly loaded candidate always
  // represents a real comparison outcome.
  always_comb begin
    w_raw = c_code_eq;
    if (w_a_gt_b) begin
      w_raw = c_code_gt;
    end else if (w_a_lt_b) begin
      w_raw = c_code_lt;
    end
  end

  // --------------------------------------------------------------------------
  // Stability filter FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cand      <= c_code_none;
      r_cnt       <= '0;
      r_committed <= c_code_none;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_committed <= w_committed_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Stability filter FSM: next-state logic
  // The committed code is only replaced once a different raw code has been
  // seen on STABLE_CYCLES+1 consecutive edges, so bounce shorter than that
  // never disturbs the displayed result.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_cand_nxt      = r_cand;
    w_cnt_nxt       = r_cnt;
    w_committed_nxt = r_committed;
    w_valid_nxt     = r_valid;
    case (r_state)
      S_IDLE: begin
        w_cand_nxt  = w_raw;
        w_cnt_nxt   = '0;
        w_state_nxt = S_SETTLING;
      end
      S_SETTLING: begin
        if (w_raw != r_cand) begin
          w_cand_nxt = w_raw;
          w_cnt_nxt  = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_committed_nxt = r_cand;
          w_valid_nxt     = 1'b1;
          w_state_nxt     = S_LOCKED;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      S_LOCKED: begin
        // Committed code stays on display while the new one qualifies.
        if (w_raw != r_committed) begin
          w_cand_nxt  = w_raw;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SETTLING;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // PWM: duty is captured only on the wrap edge so a period is never cut short
  // or stretched by a mid-period duty change.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_duty_q  <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + c_pwm_one;
      if (r_pwm_cnt == c_pwm_max) begin
        r_duty_q <= duty;
      end
    end
  end

  assign w_pwm_on = r_pwm_cnt < r_duty_q;

  // --------------------------------------------------------------------------
  // LED drive registers; the committed code is one-hot across the LEDs, so at
  // most one LED can be lit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
    end else begin
      red   <= (r_committed == c_code_gt) && w_pwm_on;
      green <= (r_committed == c_code_eq) && w_pwm_on;
      blue  <= (r_committed == c_code_lt) && w_pwm_on;
    end
  end

  assign cmp_code     = r_committed;
  assign result_valid = r_valid;

endmodule
`default_nettype wire
